// File: rtl/addsub_pipe_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry,
// mode encodings and the stage-count derivation.
package addsub_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEG   = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle between a producer/consumer and addsub_pipe.
interface addsub_pipe_if
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             ovfl;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, S, Cout, ovfl
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, S, Cout, ovfl
  );

endinterface

// File: rtl/addsub_pipe_slice.sv
// SEG-bit ripple-carry slice built from full-adder cells; also exposes the
// carry into its MSB so the top slice can flag signed overflow.
module addsub_pipe_slice #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           c_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o,
  output logic           cmsb_o
);

  logic [SEG:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o   = c[SEG];
  assign cmsb_o = c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SEG-bit ripple slice per stage,
// all stages advancing together under a single valid/ready enable.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  if ((WIDTH % SEG) != 0 || STAGES < 1) begin : g_bad_geometry
    $error("addsub_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             adv;
  logic             is_sub;
  logic             cin0;
  logic [WIDTH-1:0] b_eff;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic             cy_q  [STAGES];
  logic             vld_q [STAGES];
  logic             co_w  [STAGES];
  logic             cmsb_w[STAGES];
  logic             ovfl_q;

  // Whole pipe moves as one; an empty output register never blocks.
  assign adv          = bus.out_ready | ~vld_q[STAGES-1];
  assign bus.in_ready = adv;

  // Subtraction is A + ~B + 1, so invert B once here and force carry-in.
  assign is_sub = (bus.sub == MODE_SUB);
  assign b_eff  = bus.B ^ {WIDTH{is_sub}};
  assign cin0   = is_sub ? 1'b1 : bus.Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_d;
    logic [SEG-1:0]   s_seg;
    logic             c_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign a_in   = bus.A;
      assign b_in   = b_eff;
      assign sum_in = '0;
      assign c_in   = cin0;
      assign v_in   = bus.in_valid;
    end else begin : g_body
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign sum_in = sum_q[k-1];
      assign c_in   = cy_q[k-1];
      assign v_in   = vld_q[k-1];
    end

    addsub_pipe_slice #(.SEG(SEG)) u_slice (
      .a_i    (a_in[LO +: SEG]),
      .b_i    (b_in[LO +: SEG]),
      .c_i    (c_in),
      .s_o    (s_seg),
      .co_o   (co_w[k]),
      .cmsb_o (cmsb_w[k])
    );

    always_comb begin
      sum_d            = sum_in;
      sum_d[LO +: SEG] = s_seg;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
      end else if (adv) begin
        vld_q[k] <= v_in;
        cy_q[k]  <= co_w[k];
        sum_q[k] <= sum_d;
      end
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        a_q[k] <= a_in;
        b_q[k] <= b_in;
      end
    end
  end

  // ---- output register boundary: overflow from the top slice ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl_q <= 1'b0;
    end else if (adv) begin
      ovfl_q <= cmsb_w[STAGES-1] ^ co_w[STAGES-1];
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.S         = sum_q[STAGES-1];
  assign bus.Cout      = cy_q[STAGES-1];
  assign bus.ovfl      = ovfl_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and randomised bench for addsub_pipe at WIDTH=8, SEG=4.
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  localparam int W  = 8;
  localparam int SG = 4;
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W)) bus ();

  addsub_pipe #(.WIDTH(W), .SEG(SG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  vec_t vecs[12];
  res_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    res_t       r;
    logic [7:0] be;
    logic [8:0] t;
    be   = sub ? ~b : b;
    t    = {1'b0, a} + {1'b0, be} + {8'd0, (sub ? 1'b1 : cin)};
    r.s  = t[7:0];
    r.co = t[8];
    r.ov = (a[7] == be[7]) && (t[7] != a[7]);
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    bus.A = v.a; bus.B = v.b; bus.Cin = v.cin; bus.sub = v.sub;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_S"},     32'(bus.S),         32'(v.s));
    chk({nm, "_Cout"},  32'(bus.Cout),      32'(v.co));
    chk({nm, "_ovfl"},  32'(bus.ovfl),      32'(v.ov));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent, got, stall_cnt, produced;
    logic [7:0] held;
    res_t e;
    vec_t rv;

    //            a      b      cin   sub   s      co    ov
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[6]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{8'h7F, 8'hFF, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[11] = '{8'h08, 8'h08, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.sub = MODE_ADD;
    bus.out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_S",         32'(bus.S),         32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with a 3-cycle consumer stall
    sent = 0; got = 0; stall_cnt = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      bus.in_valid  = (sent < 10);
      bus.A = 8'(sent); bus.B = 8'(sent); bus.Cin = 1'b0; bus.sub = MODE_ADD;
      #1;
      if (!bus.out_ready) begin
        stall_cnt++;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (cyc == 4) held = bus.S;
        else chk("stall_hold_S", 32'(bus.S), 32'(held));
      end else begin
        chk("run_in_ready", 32'(bus.in_ready), 32'd1);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_S", 32'(bus.S), 32'(2 * got));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", 32'(got), 32'd10);
    chk("stream_stalls", 32'(stall_cnt), 32'd3);

    // Asynchronous reset with two beats in flight
    @(negedge clk);
    bus.A = 8'h11; bus.B = 8'h22; bus.sub = MODE_ADD; bus.Cin = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h01;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_S",     32'(bus.S),         32'h33);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_S",         32'(bus.S),         32'd0);
    chk("rst_Cout",      32'(bus.Cout),      32'd0);
    chk("rst_ovfl",      32'(bus.ovfl),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid",    32'(bus.out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(bus.in_ready),  32'd1);
    end
    rv = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    run_vec(rv, "post_rst_beat");

    // Random traffic against the behavioural model
    produced = 0; got = 0;
    for (int cyc = 0; cyc < 30000 && got < NRAND; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = (produced < NRAND) && ($urandom_range(0, 1) == 1);
      bus.A   = 8'($urandom_range(0, 255));
      bus.B   = 8'($urandom_range(0, 255));
      bus.Cin = 1'($urandom_range(0, 1));
      bus.sub = 1'($urandom_range(0, 1));
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_beat", 32'({bus.S, bus.Cout, bus.ovfl}), 32'({e.s, e.co, e.ov}));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.Cin, bus.sub));
        produced++;
      end
    end
    bus.in_valid = 1'b0;
    chk("rand_count", 32'(got), 32'(NRAND));
    chk("rand_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
